// File: rtl/branch_redirect_unit.sv
// Purpose: EX-stage branch/JAL/JALR resolver that detects fetch mispredictions and raises fetch redirects, flushes and misaligned-target exceptions.
// Latency: decision in EX cycle N; redir_valid/flush/misalign_exc are registered and visible in cycle N+1.
// Backpressure: redir_valid and redir_pc are held until redir_ready; ex_stall holds EX for the whole pending-redirect window.
//
// Ports:
//   clk, rst_n             core clock, asynchronous active-low reset
//   ex_valid, ex_is_*      EX instruction qualifier and type (JALR > JAL > branch if several are set)
//   ex_pc, ex_imm, ex_rs1  operands for target computation
//   ex_pred_taken          fetch's static prediction for conditional branches
//   branch_out             comparator result for the EX branch
//   redir_valid/ready/pc   registered redirect handshake towards fetch
//   flush                  one-cycle IF/ID kill pulse on the first redirect cycle
//   ex_stall               high while a redirect is pending
//   misalign_exc, exc_pc   one-cycle misaligned-target exception and faulting PC
// Optional build macro: BRANCH_PERF_CNT_EN adds perf_branch_cnt / perf_mispred_cnt.

module branch_redirect_unit #(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            ex_pred_taken,
    input  logic            branch_out,
    input  logic            redir_ready,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush,
    output logic            ex_stall,
    output logic            misalign_exc,
    output logic [XLEN-1:0] exc_pc
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branch_cnt,
    output logic [31:0]     perf_mispred_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    state_t state;

    // Decode with JALR > JAL > branch priority so an illegal multi-hot
    // encoding still resolves to exactly one instruction type.
    logic sel_jalr;
    logic sel_jal;
    logic sel_br;
    assign sel_jalr = ex_is_jalr;
    assign sel_jal  = ex_is_jal & ~ex_is_jalr;
    assign sel_br   = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fallthrough;
    logic [XLEN-1:0] redir_target;
    logic            taken;
    logic            need_redir;
    logic            misaligned;
    logic            align_bad;
    logic            accept;

    assign jalr_sum    = ex_rs1 + ex_imm;
    assign target      = sel_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
    assign fallthrough = ex_pc + XLEN'(4);

    assign taken        = sel_jalr | sel_jal | (sel_br & branch_out);
    assign need_redir   = sel_jalr | sel_jal | (sel_br & (taken != ex_pred_taken));
    assign redir_target = taken ? target : fallthrough;

    // 4-byte alignment checks both low bits; 2-byte (compressed) only bit 0.
    assign align_bad  = (IALIGN == 4) ? (target[1:0] != 2'b00) : target[0];
    assign misaligned = taken & align_bad;

    // EX is stalled while a redirect is pending, so its inputs only count in IDLE.
    assign accept   = ex_valid & (state == IDLE);
    assign ex_stall = (state == REDIR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            redir_valid  <= 1'b0;
            redir_pc     <= '0;
            flush        <= 1'b0;
            misalign_exc <= 1'b0;
            exc_pc       <= '0;
        end else begin
            flush        <= 1'b0;
            misalign_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        // A misaligned taken target traps instead of redirecting.
                        if (misaligned) begin
                            misalign_exc <= 1'b1;
                            exc_pc       <= ex_pc;
                        end else if (need_redir) begin
                            state       <= REDIR;
                            redir_valid <= 1'b1;
                            redir_pc    <= redir_target;
                            flush       <= 1'b1;
                        end
                    end
                end
                REDIR: begin
                    if (redir_ready) begin
                        state       <= IDLE;
                        redir_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    redir_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    // Saturating event counters for conditional branches seen in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branch_cnt  <= '0;
            perf_mispred_cnt <= '0;
        end else if (accept && sel_br) begin
            if (perf_branch_cnt != 32'hFFFF_FFFF) begin
                perf_branch_cnt <= perf_branch_cnt + 32'd1;
            end
            if (need_redir && (perf_mispred_cnt != 32'hFFFF_FFFF)) begin
                perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
module tb_branch_redirect_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs1;
    logic            ex_pred_taken;
    logic            branch_out;
    logic            redir_ready;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            flush;
    logic            ex_stall;
    logic            misalign_exc;
    logic [XLEN-1:0] exc_pc;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0]     perf_branch_cnt;
    logic [31:0]     perf_mispred_cnt;
`endif

    int checks = 0;
    int errors = 0;

    branch_redirect_unit #(.XLEN(XLEN), .IALIGN(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jal     (ex_is_jal),
        .ex_is_jalr    (ex_is_jalr),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_rs1        (ex_rs1),
        .ex_pred_taken (ex_pred_taken),
        .branch_out    (branch_out),
        .redir_ready   (redir_ready),
        .redir_valid   (redir_valid),
        .redir_pc      (redir_pc),
        .flush         (flush),
        .ex_stall      (ex_stall),
        .misalign_exc  (misalign_exc),
        .exc_pc        (exc_pc)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .perf_branch_cnt  (perf_branch_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic br, input logic jal, input logic jalr,
                          input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                          input logic [XLEN-1:0] rs1, input logic pred, input logic bo);
        ex_valid      = v;
        ex_is_branch  = br;
        ex_is_jal     = jal;
        ex_is_jalr    = jalr;
        ex_pc         = pc;
        ex_imm        = imm;
        ex_rs1        = rs1;
        ex_pred_taken = pred;
        branch_out    = bo;
    endtask

`ifdef BRANCH_PERF_CNT_EN
    // One branch in EX for a cycle; a mispredict spends one extra cycle in REDIR.
    task automatic run_branch(input logic pred, input logic bo);
        set_ex(1, 1, 0, 0, 32'h100, 32'h40, 0, pred, bo);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (pred != bo) tick();
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        redir_ready = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_redir_valid", {31'd0, redir_valid}, 0);
        chk("rst_redir_pc", redir_pc, 0);
        chk("rst_flush", {31'd0, flush}, 0);
        chk("rst_misalign", {31'd0, misalign_exc}, 0);
        chk("rst_exc_pc", exc_pc, 0);
        chk("rst_stall", {31'd0, ex_stall}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Mispredicted-not-taken branch, fetch ready immediately.
        redir_ready = 1'b1;
        set_ex(1, 1, 0, 0, 32'h100, 32'h40, 0, 0, 1);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_valid", {31'd0, redir_valid}, 1);
        chk("t1_pc", redir_pc, 32'h140);
        chk("t1_flush", {31'd0, flush}, 1);
        chk("t1_stall", {31'd0, ex_stall}, 1);
        tick();
        chk("t1_rel_valid", {31'd0, redir_valid}, 0);
        chk("t1_rel_flush", {31'd0, flush}, 0);
        chk("t1_rel_stall", {31'd0, ex_stall}, 0);

        // Predicted-taken branch that falls through.
        set_ex(1, 1, 0, 0, 32'h200, 32'h40, 0, 1, 0);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_valid", {31'd0, redir_valid}, 1);
        chk("t2_pc", redir_pc, 32'h204);
        chk("t2_flush", {31'd0, flush}, 1);
        tick();
        chk("t2_rel_valid", {31'd0, redir_valid}, 0);
        // Correctly predicted taken branch: nothing happens.
        set_ex(1, 1, 0, 0, 32'h200, 32'h40, 0, 1, 1);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2b_valid", {31'd0, redir_valid}, 0);
        chk("t2b_flush", {31'd0, flush}, 0);
        chk("t2b_stall", {31'd0, ex_stall}, 0);

        // JALR with fetch back-pressure for three cycles; EX inputs ignored meanwhile.
        redir_ready = 1'b0;
        set_ex(1, 0, 0, 1, 32'h800, 32'h10, 32'h1001, 0, 0);
        tick();
        set_ex(1, 0, 1, 0, 32'h500, 32'h8, 0, 0, 0);
        chk("t3_c1_valid", {31'd0, redir_valid}, 1);
        chk("t3_c1_pc", redir_pc, 32'h1010);
        chk("t3_c1_flush", {31'd0, flush}, 1);
        chk("t3_c1_stall", {31'd0, ex_stall}, 1);
        tick();
        chk("t3_c2_valid", {31'd0, redir_valid}, 1);
        chk("t3_c2_pc", redir_pc, 32'h1010);
        chk("t3_c2_flush", {31'd0, flush}, 0);
        chk("t3_c2_stall", {31'd0, ex_stall}, 1);
        tick();
        chk("t3_c3_valid", {31'd0, redir_valid}, 1);
        chk("t3_c3_pc", redir_pc, 32'h1010);
        chk("t3_c3_flush", {31'd0, flush}, 0);
        chk("t3_c3_stall", {31'd0, ex_stall}, 1);
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        redir_ready = 1'b1;
        tick();
        chk("t3_rel_valid", {31'd0, redir_valid}, 0);
        chk("t3_rel_stall", {31'd0, ex_stall}, 0);
        chk("t3_rel_pc_held", redir_pc, 32'h1010);

        // JAL to a misaligned target traps instead of redirecting.
        set_ex(1, 0, 1, 0, 32'h300, 32'h6, 0, 0, 0);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_exc", {31'd0, misalign_exc}, 1);
        chk("t4_exc_pc", exc_pc, 32'h300);
        chk("t4_valid", {31'd0, redir_valid}, 0);
        chk("t4_flush", {31'd0, flush}, 0);
        chk("t4_stall", {31'd0, ex_stall}, 0);
        tick();
        chk("t4_exc_pulse", {31'd0, misalign_exc}, 0);

        // Not-taken branch with a misaligned target and correct prediction: silent.
        set_ex(1, 1, 0, 0, 32'h100, 32'h2, 0, 0, 0);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_exc", {31'd0, misalign_exc}, 0);
        chk("t5_valid", {31'd0, redir_valid}, 0);

        // ex_valid low: a JAL is ignored.
        set_ex(0, 0, 1, 0, 32'h600, 32'h40, 0, 0, 0);
        tick();
        chk("t6_valid", {31'd0, redir_valid}, 0);
        chk("t6_exc", {31'd0, misalign_exc}, 0);

        // JAL and JALR both set: JALR target wins.
        set_ex(1, 1, 1, 1, 32'h700, 32'h4, 32'h2000, 0, 0);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t7_valid", {31'd0, redir_valid}, 1);
        chk("t7_pc", redir_pc, 32'h2004);
        tick();
        chk("t7_rel_valid", {31'd0, redir_valid}, 0);

        // Asynchronous reset while a redirect waits for fetch.
        redir_ready = 1'b0;
        set_ex(1, 0, 1, 0, 32'h400, 32'h20, 0, 0, 0);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t8_pre_valid", {31'd0, redir_valid}, 1);
        chk("t8_pre_flush", {31'd0, flush}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_rst_valid", {31'd0, redir_valid}, 0);
        chk("t8_rst_stall", {31'd0, ex_stall}, 0);
        chk("t8_rst_flush", {31'd0, flush}, 0);
        chk("t8_rst_pc", redir_pc, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t8_post_valid", {31'd0, redir_valid}, 0);
        chk("t8_post_stall", {31'd0, ex_stall}, 0);

`ifdef BRANCH_PERF_CNT_EN
        chk("perf_rst_br", perf_branch_cnt, 0);
        chk("perf_rst_mp", perf_mispred_cnt, 0);
        redir_ready = 1'b1;
        run_branch(1, 1);
        run_branch(0, 1);
        run_branch(0, 0);
        run_branch(1, 0);
        run_branch(1, 1);
        chk("perf_branch_cnt", perf_branch_cnt, 5);
        chk("perf_mispred_cnt", perf_mispred_cnt, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
